// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous IROM,
// presents pc/pc+4/inst to IF/ID, and keeps fetch/stall/flush counters.
//
// Ports:
//   clk, rst_n                clock, async active-low reset
//   stop                      stall from hazard unit
//   redirect, redirect_pc     taken branch/jump and its target
//   irom_addr, irom_data      IROM word address (comb.) and read data
//   if_pc, if_pc4             PC presented and PC+4
//   if_inst, if_valid         instruction presented and its validity
//   flush_id                  IF/ID clear strobe (same as redirect)
//   misalign_err              sticky: a redirect target had nonzero [1:0]
//   cnt_fetch/stall/flush     saturating performance counters
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stop,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_data,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc4,
  output logic [31:0]        if_inst,
  output logic               if_valid,
  output logic               flush_id,
  output logic               misalign_err,
  output logic [31:0]        cnt_fetch,
  output logic [31:0]        cnt_stall,
  output logic [31:0]        cnt_flush
);

  // vld_q doubles as the state: BOOT until the first fetch is in flight.
  localparam logic BOOT = 1'b0;
  localparam logic RUN  = 1'b1;

  logic [31:0] pc_q;
  logic        vld_q;
  logic [31:0] nxt;
  logic        mis_q;
  logic [31:0] fetch_q;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  logic inc_fetch;
  logic inc_stall;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    // Stop at all-ones instead of wrapping.
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

  // Redirect beats everything; BOOT and stall both re-read pc_q.
  always_comb begin
    nxt = pc_q + 32'd4;
    if (redirect) begin
      nxt = {redirect_pc[31:2], 2'b00};
    end else if (vld_q == BOOT) begin
      nxt = pc_q;
    end else if (stop) begin
      nxt = pc_q;
    end
  end

  assign irom_addr = nxt[IROM_AW+1:2];

  assign inc_fetch = vld_q & ~stop & ~redirect;
  assign inc_stall = vld_q &  stop & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      vld_q <= BOOT;
    end else begin
      pc_q  <= nxt;
      vld_q <= RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      mis_q <= 1'b1;
    end
  end

  // Counters are written every edge so the stored value always
  // reflects the current (possibly saturated) count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= 32'd0;
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      fetch_q <= sat_inc(fetch_q, inc_fetch);
      stall_q <= sat_inc(stall_q, inc_stall);
      flush_q <= sat_inc(flush_q, redirect);
    end
  end

  assign if_pc        = pc_q;
  assign if_pc4       = pc_q + 32'd4;
  assign if_inst      = vld_q ? irom_data : NOP_INST;
  assign if_valid     = vld_q;
  assign flush_id     = redirect;
  assign misalign_err = mis_q;
  assign cnt_fetch    = fetch_q;
  assign cnt_stall    = stall_q;
  assign cnt_flush    = flush_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with a behavioural 1-cycle IROM
// whose word i holds 0x1000_0000 + i.
module tb_if_fetch_stage;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stop;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] irom_addr;
  logic [31:0]   irom_data;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc4;
  logic [31:0]   if_inst;
  logic          if_valid;
  logic          flush_id;
  logic          misalign_err;
  logic [31:0]   cnt_fetch;
  logic [31:0]   cnt_stall;
  logic [31:0]   cnt_flush;

  int ncmp = 0;
  int nerr = 0;

  logic [63:0] sb[$];

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IROM_AW  (AW),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stop         (stop),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .irom_addr    (irom_addr),
    .irom_data    (irom_data),
    .if_pc        (if_pc),
    .if_pc4       (if_pc4),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .flush_id     (flush_id),
    .misalign_err (misalign_err),
    .cnt_fetch    (cnt_fetch),
    .cnt_stall    (cnt_stall),
    .cnt_flush    (cnt_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] w);
    return 32'h1000_0000 + w;
  endfunction

  always_ff @(posedge clk) irom_data <= rom(32'(irom_addr));

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] e;
    rst_n = 1'b0;
    stop = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    ncmp++;
    if (if_pc !== 32'h0 || if_pc4 !== 32'h4) begin
      nerr++;
      $display("FAIL reset_pc: pc=%h pc4=%h want 0/4", if_pc, if_pc4);
    end
    ncmp++;
    if (if_inst !== 32'h13 || if_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_inst: inst=%h v=%b want 13/0", if_inst, if_valid);
    end
    ncmp++;
    if (cnt_fetch !== 0 || cnt_stall !== 0 || cnt_flush !== 0 ||
        misalign_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_cnt: f=%0d s=%0d fl=%0d m=%b want 0",
               cnt_fetch, cnt_stall, cnt_flush, misalign_err);
    end
    rst_n = 1'b1;
    #1;
    ncmp++;
    if (if_inst !== 32'h13 || if_valid !== 1'b0) begin
      nerr++;
      $display("FAIL boot_cycle0: inst=%h v=%b want 13/0",
               if_inst, if_valid);
    end
    for (int i = 0; i < 3; i++) sb.push_back({32'(4 * i), rom(32'(i))});
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = sb.pop_front();
      ncmp++;
      if (if_pc !== e[63:32] || if_inst !== e[31:0] || if_valid !== 1'b1) begin
        nerr++;
        $display("FAIL seq_fetch%0d: pc=%h inst=%h want %h %h",
                 i, if_pc, if_inst, e[63:32], e[31:0]);
      end
      ncmp++;
      if (cnt_fetch !== 32'(i)) begin
        nerr++;
        $display("FAIL seq_cnt%0d: got %0d want %0d", i, cnt_fetch, i);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    stop = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back({32'h8, rom(32'd2)});
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = sb.pop_front();
      ncmp++;
      if (if_pc !== e[63:32] || if_inst !== e[31:0]) begin
        nerr++;
        $display("FAIL stall_hold%0d: pc=%h inst=%h want %h %h",
                 i, if_pc, if_inst, e[63:32], e[31:0]);
      end
    end
    ncmp++;
    if (cnt_stall !== 32'd3 || cnt_fetch !== 32'd2) begin
      nerr++;
      $display("FAIL stall_cnt: s=%0d f=%0d want 3/2", cnt_stall, cnt_fetch);
    end
    stop = 1'b0;
    sb.push_back({32'hC, rom(32'd3)});
    sb.push_back({32'h10, rom(32'd4)});
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = sb.pop_front();
      ncmp++;
      if (if_pc !== e[63:32] || if_inst !== e[31:0]) begin
        nerr++;
        $display("FAIL stall_release%0d: pc=%h inst=%h want %h %h",
                 i, if_pc, if_inst, e[63:32], e[31:0]);
      end
    end
    ncmp++;
    if (cnt_fetch !== 32'd4) begin
      nerr++;
      $display("FAIL release_cnt: got %0d want 4", cnt_fetch);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    ncmp++;
    if (flush_id !== 1'b1) begin
      nerr++;
      $display("FAIL flush_strobe: got %b want 1", flush_id);
    end
    cyc();
    redirect = 1'b0;
    #1;
    ncmp++;
    if (if_pc !== 32'h40 || if_inst !== rom(32'd16) || flush_id !== 1'b0) begin
      nerr++;
      $display("FAIL redirect_tgt: pc=%h inst=%h fl=%b want 40 %h 0",
               if_pc, if_inst, flush_id, rom(32'd16));
    end
    ncmp++;
    if (cnt_flush !== 32'd1 || cnt_fetch !== 32'd4) begin
      nerr++;
      $display("FAIL redirect_cnt: fl=%0d f=%0d want 1/4",
               cnt_flush, cnt_fetch);
    end
  endtask

  task automatic test_redirect_stop();
    redirect = 1'b1;
    stop = 1'b1;
    redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    stop = 1'b0;
    ncmp++;
    if (if_pc !== 32'h80 || if_inst !== rom(32'd32)) begin
      nerr++;
      $display("FAIL redir_stop_tgt: pc=%h inst=%h want 80 %h",
               if_pc, if_inst, rom(32'd32));
    end
    ncmp++;
    if (cnt_stall !== 32'd3 || cnt_flush !== 32'd2) begin
      nerr++;
      $display("FAIL redir_stop_cnt: s=%0d fl=%0d want 3/2",
               cnt_stall, cnt_flush);
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1;
    redirect_pc = 32'h22;
    cyc();
    redirect = 1'b0;
    ncmp++;
    if (if_pc !== 32'h20 || if_inst !== rom(32'd8) || misalign_err !== 1'b1) begin
      nerr++;
      $display("FAIL misalign_set: pc=%h inst=%h m=%b want 20 %h 1",
               if_pc, if_inst, misalign_err, rom(32'd8));
    end
    cyc();
    ncmp++;
    if (if_pc !== 32'h24 || misalign_err !== 1'b1) begin
      nerr++;
      $display("FAIL misalign_hold: pc=%h m=%b want 24 1",
               if_pc, misalign_err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (misalign_err !== 1'b0 || if_pc !== 32'h0 || if_valid !== 1'b0 ||
        if_inst !== 32'h13 || cnt_flush !== 32'd0) begin
      nerr++;
      $display("FAIL async_reset: m=%b pc=%h v=%b inst=%h fl=%0d",
               misalign_err, if_pc, if_valid, if_inst, cnt_flush);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    ncmp++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 ||
        if_inst !== rom(32'h3FFF)) begin
      nerr++;
      $display("FAIL wrap_top: pc=%h pc4=%h inst=%h want fffffffc 0 %h",
               if_pc, if_pc4, if_inst, rom(32'h3FFF));
    end
    cyc();
    ncmp++;
    if (if_pc !== 32'h0 || if_inst !== rom(32'd0)) begin
      nerr++;
      $display("FAIL wrap_zero: pc=%h inst=%h want 0 %h",
               if_pc, if_inst, rom(32'd0));
    end
  endtask

  task automatic test_saturate();
    stop = 1'b1;
    force dut.fetch_q = 32'hFFFF_FFFF;
    cyc();
    release dut.fetch_q;
    stop = 1'b0;
    cyc();
    ncmp++;
    if (cnt_fetch !== 32'hFFFF_FFFF) begin
      nerr++;
      $display("FAIL sat_fetch1: got %h want ffffffff", cnt_fetch);
    end
    cyc();
    ncmp++;
    if (cnt_fetch !== 32'hFFFF_FFFF) begin
      nerr++;
      $display("FAIL sat_fetch2: got %h want ffffffff", cnt_fetch);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stop();
    test_misalign();
    test_wrap();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
